// File: rtl/reg_bank_pkg.sv
// Shared sizes and FSM state type for the general register bank write side.
package reg_bank_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } bank_state_t;

endpackage

// File: rtl/write_decoder_3_to_8.sv
// One-hot decode of a register index plus enable into per-register load strobes.
module write_decoder_3_to_8
    import reg_bank_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  en,
    output logic [NUM_REGS-1:0]   load
);

    always_comb begin
        load = '0;
        if (en) begin
            load[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_writer.sv
// Eight-entry register bank with one write port and a one-register-per-cycle clear sweep.
module reg_bank_writer #(
    parameter int unsigned           DATA_W      = 16,
    parameter logic [DATA_W-1:0]     CLEAR_VALUE = '0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Write_En,
    input  logic [2:0]        Write_Addr,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Clear_Req,
    output logic              Write_Ack,
    output logic              Busy,
    output logic [DATA_W-1:0] Reg_A,
    output logic [DATA_W-1:0] Reg_B,
    output logic [DATA_W-1:0] Reg_C,
    output logic [DATA_W-1:0] Reg_D,
    output logic [DATA_W-1:0] Reg_E,
    output logic [DATA_W-1:0] Reg_F,
    output logic [DATA_W-1:0] Reg_G,
    output logic [DATA_W-1:0] Reg_H
);

    import reg_bank_pkg::*;

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    bank_state_t             state;
    bank_state_t             state_next;
    logic [REG_ADDR_W-1:0]   idx;
    logic [REG_ADDR_W-1:0]   idx_next;
    logic                    ack_next;
    logic                    dec_en;
    logic [REG_ADDR_W-1:0]   dec_addr;
    logic [NUM_REGS-1:0]     load;
    logic [DATA_W-1:0]       load_data;
    logic [DATA_W-1:0]       regs [NUM_REGS];

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            Write_Ack <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            Write_Ack <= ack_next;
        end
    end

    // The sweep borrows the write decoder by steering its index onto the address input.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        ack_next   = 1'b0;
        dec_en     = 1'b0;
        dec_addr   = Write_Addr;
        load_data  = Write_Data;
        case (state)
            IDLE: begin
                if (Clear_Req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end else if (Write_En) begin
                    dec_en   = 1'b1;
                    ack_next = 1'b1;
                end
            end
            CLEAR: begin
                dec_en    = 1'b1;
                dec_addr  = idx;
                load_data = CLEAR_VALUE;
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx + REG_ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    write_decoder_3_to_8 u_decoder (
        .addr (dec_addr),
        .en   (dec_en),
        .load (load)
    );

    always_ff @(posedge Clock) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!Reset_n) begin
                regs[i] <= '0;
            end else if (load[i]) begin
                regs[i] <= load_data;
            end
        end
    end

    assign Busy  = (state == CLEAR);
    assign Reg_A = regs[0];
    assign Reg_B = regs[1];
    assign Reg_C = regs[2];
    assign Reg_D = regs[3];
    assign Reg_E = regs[4];
    assign Reg_F = regs[5];
    assign Reg_G = regs[6];
    assign Reg_H = regs[7];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed scoreboard bench for reg_bank_writer: a reference model queues the expected
// bank image per edge and every register, Write_Ack and Busy are compared after the edge.
module tb_reg_bank_writer;

    localparam int unsigned     W       = 16;
    localparam logic [W-1:0]    CLR_VAL = 16'h0000;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          Write_En;
    logic [2:0]    Write_Addr;
    logic [W-1:0]  Write_Data;
    logic          Clear_Req;
    logic          Write_Ack;
    logic          Busy;
    logic [W-1:0]  Reg_A, Reg_B, Reg_C, Reg_D, Reg_E, Reg_F, Reg_G, Reg_H;

    reg_bank_writer #(
        .DATA_W      (W),
        .CLEAR_VALUE (CLR_VAL)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Write_En   (Write_En),
        .Write_Addr (Write_Addr),
        .Write_Data (Write_Data),
        .Clear_Req  (Clear_Req),
        .Write_Ack  (Write_Ack),
        .Busy       (Busy),
        .Reg_A      (Reg_A),
        .Reg_B      (Reg_B),
        .Reg_C      (Reg_C),
        .Reg_D      (Reg_D),
        .Reg_E      (Reg_E),
        .Reg_F      (Reg_F),
        .Reg_G      (Reg_G),
        .Reg_H      (Reg_H)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0][W-1:0] regs;
        logic              ack;
        logic              busy;
    } snap_t;

    snap_t             exp_q [$];
    logic [7:0][W-1:0] m_regs;
    logic              m_busy;
    logic              m_ack;
    int unsigned       m_idx;
    logic [7:0][W-1:0] act_regs;
    int                vectors     = 0;
    int                miscompares = 0;
    int                busy_cnt;

    assign act_regs = {Reg_H, Reg_G, Reg_F, Reg_E, Reg_D, Reg_C, Reg_B, Reg_A};

    function automatic logic [W-1:0] mux8(input logic [2:0] sel);
        case (sel)
            3'd0:    return Reg_A;
            3'd1:    return Reg_B;
            3'd2:    return Reg_C;
            3'd3:    return Reg_D;
            3'd4:    return Reg_E;
            3'd5:    return Reg_F;
            3'd6:    return Reg_G;
            default: return Reg_H;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic en, input logic [2:0] addr, input logic [W-1:0] data,
                        input logic clr, input logic rstn);
        snap_t e;
        @(negedge Clock);
        Write_En   = en;
        Write_Addr = addr;
        Write_Data = data;
        Clear_Req  = clr;
        Reset_n    = rstn;
        if (!rstn) begin
            m_regs = '0;
            m_busy = 1'b0;
            m_ack  = 1'b0;
            m_idx  = 0;
        end else if (!m_busy) begin
            m_ack = 1'b0;
            if (clr) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end else if (en) begin
                m_regs[addr] = data;
                m_ack        = 1'b1;
            end
        end else begin
            m_ack          = 1'b0;
            m_regs[m_idx]  = CLR_VAL;
            if (m_idx == 7) m_busy = 1'b0;
            else            m_idx++;
        end
        e.regs = m_regs;
        e.ack  = m_ack;
        e.busy = m_busy;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 8; i++) begin
                check($sformatf("reg%0d", i), act_regs[i], e.regs[i]);
            end
            check("write_ack", {15'b0, Write_Ack}, {15'b0, e.ack});
            check("busy", {15'b0, Busy}, {15'b0, e.busy});
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [W-1:0] data);
        step(1'b1, addr, data, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, '0, 1'b0, 1'b1);
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), W'(i + 1));
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        Write_En   = 1'b0;
        Write_Addr = '0;
        Write_Data = '0;
        Clear_Req  = 1'b0;
        m_regs     = '0;
        m_busy     = 1'b0;
        m_ack      = 1'b0;
        m_idx      = 0;

        // initial reset, arbitrary writes, then reset held for two edges
        step(1'b0, 3'd0, '0, 1'b0, 1'b0);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0);
        wr(3'd2, 16'h55AA);
        wr(3'd6, 16'h1357);
        step(1'b1, 3'd1, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0);
        idle();

        // single write
        wr(3'd3, 16'hBEEF);
        check("regD_beef", Reg_D, 16'hBEEF);
        idle();

        // write all eight back to back, then mux cross-check
        preload();
        check("mux_sel2", mux8(3'd2), 16'h0003);
        idle();

        // clear colliding with a write to F
        busy_cnt = 0;
        step(1'b1, 3'd5, 16'h1234, 1'b1, 1'b1);
        if (Busy) busy_cnt++;
        check("regF_not_1234", {15'b0, Reg_F === 16'h1234}, '0);
        for (int i = 0; i < 9; i++) begin
            idle();
            if (Busy) busy_cnt++;
            check("regF_not_1234", {15'b0, Reg_F === 16'h1234}, '0);
        end
        check("busy_cycles", W'(busy_cnt), 16'd8);

        // write attempted during sweep cycle 3
        preload();
        step(1'b0, 3'd0, '0, 1'b1, 1'b1);
        idle();
        idle();
        wr(3'd7, 16'hAAAA);
        for (int i = 0; i < 6; i++) idle();
        check("regH_after_sweep", Reg_H, 16'h0000);

        // reset in the middle of a sweep, then a write shortly after release
        preload();
        step(1'b0, 3'd0, '0, 1'b1, 1'b1);
        idle();
        idle();
        idle();
        step(1'b1, 3'd4, 16'h7777, 1'b1, 1'b0);
        idle();
        wr(3'd4, 16'hC0DE);
        check("post_reset_ack", {15'b0, Write_Ack}, 16'd1);
        idle();

        // Clear_Req held high across several sweeps with writes mixed in
        preload();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 3'(i), W'(16'h0100 + i), 1'b1, 1'b1);
        end
        idle();
        wr(3'd1, 16'h4242);
        idle();

        check("queue_drained", W'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
